// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - packs UART bytes into big-endian halfwords, buffers them, writes them to SRAM
module uart_word_packer #(
    parameter int ADDR_W     = 16,
    parameter int START_ADDR = 1,
    parameter int FIFO_AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_ferr,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    input  logic              wr_done,
    output logic              fifo_full,
    output logic              overflow,
    output logic [ADDR_W-1:0] words_wr
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic sync1;
    logic sync2;
    logic sync3;
    logic byte_stb;

    logic       phase_lo;
    logic [7:0] hold_hi;
    logic       push;
    logic       push_ok;
    logic [15:0] push_data;

    logic [15:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             fifo_empty;
    logic [15:0]      head;

    logic load;
    logic pop;

    // rx_valid comes from another clock domain; third flop gives the rising-edge reference
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= rx_valid;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign byte_stb = sync2 & ~sync3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_lo <= 1'b0;
            hold_hi  <= 8'h00;
        end else if (byte_stb) begin
            if (rx_ferr) begin
                phase_lo <= 1'b0;
            end else if (!phase_lo) begin
                hold_hi  <= rx_data;
                phase_lo <= 1'b1;
            end else begin
                phase_lo <= 1'b0;
            end
        end
    end

    assign push      = byte_stb & ~rx_ferr & phase_lo;
    assign push_data = {hold_hi, rx_data};

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    // a pop in the same cycle frees the slot the push lands in
    assign push_ok    = push & (~fifo_full | pop);
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (wr_done) begin
                    pop        = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign wr_req = (state == S_REQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wr_addr  <= ADDR_W'(START_ADDR);
            wr_data  <= 16'h0000;
            words_wr <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                wr_data <= head;
            end
            if (pop) begin
                wr_addr  <= wr_addr + 1'b1;
                words_wr <= words_wr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_packer.sv
// tb/tb_uart_word_packer.sv - directed self-checking bench for uart_word_packer
module tb_uart_word_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ferr = 1'b0;

    logic        wr_req_a;
    logic [15:0] wr_addr_a;
    logic [15:0] wr_data_a;
    logic        wr_done_a;
    logic        fifo_full_a;
    logic        overflow_a;
    logic [15:0] words_wr_a;

    logic        wr_req_b;
    logic [3:0]  wr_addr_b;
    logic [15:0] wr_data_b;
    logic        wr_done_b;
    logic        fifo_full_b;
    logic        overflow_b;
    logic [3:0]  words_wr_b;

    int total = 0;
    int bad = 0;

    logic ack_en_a = 1'b0;
    logic ack_en_b = 1'b1;
    logic resp_a = 1'b0;
    logic resp_b = 1'b0;
    logic done_manual = 1'b0;
    int   cnt_a = 0;
    int   cnt_b = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    assign wr_done_a = resp_a | done_manual;
    assign wr_done_b = resp_b;

    always #5 clk = ~clk;

    uart_word_packer dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
        .wr_req(wr_req_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_done(wr_done_a),
        .fifo_full(fifo_full_a), .overflow(overflow_a), .words_wr(words_wr_a)
    );

    uart_word_packer #(.ADDR_W(4), .START_ADDR(15), .FIFO_AW(2)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
        .wr_req(wr_req_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_done(wr_done_b),
        .fifo_full(fifo_full_b), .overflow(overflow_b), .words_wr(words_wr_b)
    );

    // SRAM controller model: answers a request two cycles after it appears
    always @(negedge clk) begin
        if (!rst) begin
            resp_a = 1'b0; cnt_a = 0;
            resp_b = 1'b0; cnt_b = 0;
        end else begin
            if (resp_a) begin
                resp_a = 1'b0; cnt_a = 0;
            end else if (ack_en_a && wr_req_a) begin
                cnt_a++;
                if (cnt_a >= 2) resp_a = 1'b1;
            end else begin
                cnt_a = 0;
            end
            if (resp_b) begin
                resp_b = 1'b0; cnt_b = 0;
            end else if (ack_en_b && wr_req_b) begin
                cnt_b++;
                if (cnt_b >= 2) resp_b = 1'b1;
            end else begin
                cnt_b = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (wr_req_a && wr_done_a) q_a.push_back({wr_addr_a, wr_data_a});
        if (wr_req_b && wr_done_b) q_b.push_back({12'h000, wr_addr_b, wr_data_b});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ferr);
        @(negedge clk);
        rx_data  = d;
        rx_ferr  = ferr;
        rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_a(input int n);
        int cyc;
        cyc = 0;
        while (q_a.size() < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_a_count", q_a.size(), n);
    endtask

    task automatic wait_b(input int n);
        int cyc;
        cyc = 0;
        while (q_b.size() < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_b_count", q_b.size(), n);
    endtask

    initial begin
        logic [15:0] exp4 [4];
        logic [15:0] exp6 [5];
        exp4 = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        exp6 = '{16'h1011, 16'h1213, 16'h1415, 16'h1617, 16'h1819};

        // test 1: reset state and reset in the middle of a request
        repeat (2) @(negedge clk);
        #1;
        check("rst_wr_req", wr_req_a, 0);
        check("rst_wr_addr", wr_addr_a, 16'd1);
        check("rst_wr_data", wr_data_a, 0);
        check("rst_fifo_full", fifo_full_a, 0);
        check("rst_overflow", overflow_a, 0);
        check("rst_addr_b", wr_addr_b, 4'd15);
        rst = 1'b1;
        ack_en_a = 1'b0;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        repeat (3) @(negedge clk);
        check("t1_req_before", wr_req_a, 1);
        rst = 1'b0;
        #1;
        check("t1_req_async_drop", wr_req_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t1_addr_after", wr_addr_a, 16'd1);
        check("t1_words_after", words_wr_a, 0);
        check("t1_req_after", wr_req_a, 0);

        // test 2: one halfword written
        q_a.delete();
        ack_en_a = 1'b1;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        wait_a(1);
        if (q_a.size() >= 1) check("t2_write", q_a[0], {16'd1, 16'h1234});
        repeat (4) @(negedge clk);
        check("t2_addr", wr_addr_a, 16'd2);
        check("t2_words", words_wr_a, 16'd1);

        // test 3: framing error drops the byte
        q_a.delete();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        wait_a(1);
        if (q_a.size() >= 1) check("t3_write", q_a[0], {16'd2, 16'h5566});
        repeat (20) @(negedge clk);
        check("t3_single", q_a.size(), 1);
        check("t3_words", words_wr_a, 16'd2);

        // test 4: overflow with wr_done held off
        do_reset();
        q_a.delete();
        ack_en_a = 1'b0;
        for (int i = 1; i <= 10; i++) send_byte(8'(i), 1'b0);
        check("t4_full", fifo_full_a, 1);
        check("t4_overflow", overflow_a, 1);
        ack_en_a = 1'b1;
        wait_a(4);
        for (int i = 0; i < 4; i++)
            if (q_a.size() > i) check("t4_write", q_a[i], {16'(i + 1), exp4[i]});
        repeat (20) @(negedge clk);
        check("t4_no_extra", q_a.size(), 4);
        check("t4_not_full", fifo_full_a, 0);
        check("t4_overflow_sticky", overflow_a, 1);

        // test 6: push and pop in the same cycle while full
        do_reset();
        q_a.delete();
        ack_en_a = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0);
        check("t6_full", fifo_full_a, 1);
        check("t6_req", wr_req_a, 1);
        send_byte(8'h18, 1'b0);
        @(negedge clk);
        rx_data  = 8'h19;
        rx_ferr  = 1'b0;
        rx_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        done_manual = 1'b1;
        @(negedge clk);
        done_manual = 1'b0;
        check("t6_no_overflow", overflow_a, 0);
        check("t6_still_full", fifo_full_a, 1);
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        ack_en_a = 1'b1;
        wait_a(5);
        for (int i = 0; i < 5; i++)
            if (q_a.size() > i) check("t6_write", q_a[i], {16'(i + 1), exp6[i]});
        check("t6_overflow_end", overflow_a, 0);

        // test 5: narrow address wraps from 15 to 0
        do_reset();
        q_b.delete();
        ack_en_b = 1'b1;
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hC4, 1'b0);
        wait_b(2);
        if (q_b.size() >= 1) check("t5_first", q_b[0], {16'd15, 16'hC1C2});
        if (q_b.size() >= 2) check("t5_wrap", q_b[1], {16'd0, 16'hC3C4});
        repeat (4) @(negedge clk);
        check("t5_addr_next", wr_addr_b, 4'd1);
        check("t5_words", words_wr_b, 4'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
